// File: rtl/pcs_rx_synchronizer.sv
// 1000BASE-X receive code-group synchronizer: comma/parity acquisition, cgbad flagging, sync-loss tracking.
// One code group per GTX_CLK edge, all outputs registered one cycle behind RX_CODE_GROUP; no backpressure.
module pcs_rx_synchronizer (
    input  logic       GTX_CLK,
    input  logic       RESET,
    input  logic [9:0] RX_CODE_GROUP,
    output logic       SYNC_STATUS,
    output logic       RX_EVEN,
    output logic [9:0] SUDI,
    output logic       SUDI_BAD
);

    typedef enum logic [3:0] {
        LOSS_OF_SYNC, COMMA_DETECT_1, COMMA_DETECT_2, COMMA_DETECT_3,
        ACQUIRE_SYNC_1, ACQUIRE_SYNC_2,
        SYNC_ACQUIRED_1, SYNC_ACQUIRED_2, SYNC_ACQUIRED_2A,
        SYNC_ACQUIRED_3, SYNC_ACQUIRED_3A, SYNC_ACQUIRED_4, SYNC_ACQUIRED_4A
    } state_t;

    state_t     r_state, w_next;
    logic [1:0] r_good_cgs, w_next_good;
    logic       r_sync, r_rx_even, r_sudi_bad;
    logic [9:0] r_sudi;

    logic w_valid, w_is_k, w_comma, w_data, w_exp_even, w_cgbad, w_cggood;
    logic w_enter_cd, w_next_sync, w_next_quiet;

    // Both running-disparity encodings of every code group the link may carry.
    always_comb begin
        w_valid = 1'b0;
        w_is_k  = 1'b0;
        case (RX_CODE_GROUP)
            10'h274, 10'h18B, 10'h279, 10'h189, 10'h275, 10'h185,
            10'h273, 10'h18C, 10'h272, 10'h18D, 10'h296,
            10'h1B4, 10'h24B, 10'h1B9, 10'h249, 10'h1B5, 10'h245,
            10'h1B3, 10'h24C, 10'h2AA: w_valid = 1'b1;
            10'h0FA, 10'h305, 10'h3A8, 10'h057, 10'h368, 10'h097,
            10'h2E8, 10'h117: begin
                w_valid = 1'b1;
                w_is_k  = 1'b1;
            end
            default: ;
        endcase
    end

    assign w_comma    = (RX_CODE_GROUP[9:3] == 7'b0011111) || (RX_CODE_GROUP[9:3] == 7'b1100000);
    assign w_data     = w_valid && !w_comma && !w_is_k;
    assign w_exp_even = ~r_rx_even;
    assign w_cgbad    = !w_valid || (w_comma && !w_exp_even);
    assign w_cggood   = !w_cgbad;

    always_comb begin
        w_next      = r_state;
        w_next_good = r_good_cgs;
        case (r_state)
            LOSS_OF_SYNC:   if (w_comma) w_next = COMMA_DETECT_1;
            COMMA_DETECT_1: w_next = w_data ? ACQUIRE_SYNC_1 : LOSS_OF_SYNC;
            COMMA_DETECT_2: w_next = w_data ? ACQUIRE_SYNC_2 : LOSS_OF_SYNC;
            COMMA_DETECT_3: w_next = w_data ? SYNC_ACQUIRED_1 : LOSS_OF_SYNC;
            ACQUIRE_SYNC_1: begin
                if (w_cgbad)                      w_next = LOSS_OF_SYNC;
                else if (w_comma && w_exp_even)   w_next = COMMA_DETECT_2;
            end
            ACQUIRE_SYNC_2: begin
                if (w_cgbad)                      w_next = LOSS_OF_SYNC;
                else if (w_comma && w_exp_even)   w_next = COMMA_DETECT_3;
            end
            SYNC_ACQUIRED_1: begin
                if (w_cgbad) begin
                    w_next      = SYNC_ACQUIRED_2;
                    w_next_good = 2'd0;
                end
            end
            SYNC_ACQUIRED_2, SYNC_ACQUIRED_3, SYNC_ACQUIRED_4: begin
                if (w_cgbad) begin
                    w_next      = (r_state == SYNC_ACQUIRED_2) ? SYNC_ACQUIRED_3 :
                                  (r_state == SYNC_ACQUIRED_3) ? SYNC_ACQUIRED_4 : LOSS_OF_SYNC;
                    w_next_good = 2'd0;
                end else begin
                    w_next      = (r_state == SYNC_ACQUIRED_2) ? SYNC_ACQUIRED_2A :
                                  (r_state == SYNC_ACQUIRED_3) ? SYNC_ACQUIRED_3A : SYNC_ACQUIRED_4A;
                    w_next_good = 2'd1;
                end
            end
            SYNC_ACQUIRED_2A, SYNC_ACQUIRED_3A, SYNC_ACQUIRED_4A: begin
                if (w_cgbad) begin
                    w_next      = (r_state == SYNC_ACQUIRED_2A) ? SYNC_ACQUIRED_3 :
                                  (r_state == SYNC_ACQUIRED_3A) ? SYNC_ACQUIRED_4 : LOSS_OF_SYNC;
                    w_next_good = 2'd0;
                end else if (w_cggood && r_good_cgs == 2'd3) begin
                    // Four good code groups in a row climb back one level.
                    w_next      = (r_state == SYNC_ACQUIRED_2A) ? SYNC_ACQUIRED_1 :
                                  (r_state == SYNC_ACQUIRED_3A) ? SYNC_ACQUIRED_2 : SYNC_ACQUIRED_3;
                    w_next_good = 2'd0;
                end else begin
                    w_next_good = r_good_cgs + 2'd1;
                end
            end
            default: w_next = LOSS_OF_SYNC;
        endcase
    end

    assign w_enter_cd   = (w_next == COMMA_DETECT_1) || (w_next == COMMA_DETECT_2) ||
                          (w_next == COMMA_DETECT_3);
    assign w_next_quiet = w_enter_cd || (w_next == LOSS_OF_SYNC);
    assign w_next_sync  = (w_next >= SYNC_ACQUIRED_1);

    always_ff @(posedge GTX_CLK or posedge RESET) begin
        if (RESET) begin
            r_state    <= LOSS_OF_SYNC;
            r_good_cgs <= 2'd0;
            r_sync     <= 1'b0;
            r_rx_even  <= 1'b0;
            r_sudi     <= 10'h000;
            r_sudi_bad <= 1'b0;
        end else begin
            r_state    <= w_next;
            r_good_cgs <= w_next_good;
            r_sync     <= w_next_sync;
            r_rx_even  <= w_enter_cd ? 1'b1 : w_exp_even;
            r_sudi     <= RX_CODE_GROUP;
            r_sudi_bad <= w_cgbad && !w_next_quiet;
        end
    end

    assign SYNC_STATUS = r_sync;
    assign RX_EVEN     = r_rx_even;
    assign SUDI        = r_sudi;
    assign SUDI_BAD    = r_sudi_bad;

endmodule

// File: tb/tb_pcs_rx_synchronizer.sv
// Directed plus random bench for pcs_rx_synchronizer, checked against an abstract sync-level model.
module tb_pcs_rx_synchronizer;

    logic       GTX_CLK = 1'b0;
    logic       RESET = 1'b1;
    logic [9:0] RX_CODE_GROUP = 10'h000;
    logic       SYNC_STATUS, RX_EVEN, SUDI_BAD;
    logic [9:0] SUDI;

    int total = 0;
    int bad = 0;

    localparam logic [9:0] K28P5N = 10'h0FA;
    localparam logic [9:0] K28P5P = 10'h305;
    localparam logic [9:0] D16P2  = 10'h245;
    localparam logic [9:0] D0P0   = 10'h274;

    // Entries 0..19 are data code groups, 20..27 are K code groups.
    localparam logic [9:0] CG_TBL [28] = '{
        10'h274, 10'h18B, 10'h279, 10'h189, 10'h275, 10'h185, 10'h273, 10'h18C,
        10'h272, 10'h18D, 10'h296, 10'h1B4, 10'h24B, 10'h1B9, 10'h249, 10'h1B5,
        10'h245, 10'h1B3, 10'h24C, 10'h2AA,
        10'h0FA, 10'h305, 10'h3A8, 10'h057, 10'h368, 10'h097, 10'h2E8, 10'h117};

    pcs_rx_synchronizer dut (
        .GTX_CLK      (GTX_CLK),
        .RESET        (RESET),
        .RX_CODE_GROUP(RX_CODE_GROUP),
        .SYNC_STATUS  (SYNC_STATUS),
        .RX_EVEN      (RX_EVEN),
        .SUDI         (SUDI),
        .SUDI_BAD     (SUDI_BAD)
    );

    always #5 GTX_CLK = ~GTX_CLK;

    // Model: out of sync, m_acq counts accepted commas and m_need says a /D/ must follow;
    // in sync, m_lvl is how many unrecovered errors remain and m_good the current good run.
    bit         m_insync, m_need, m_even, m_bad;
    int         m_acq, m_lvl, m_good;
    logic [9:0] m_sudi;

    function automatic bit in_list(logic [9:0] cg, int lo, int hi);
        for (int i = lo; i < hi; i++)
            if (CG_TBL[i] == cg) return 1'b1;
        return 1'b0;
    endfunction

    task automatic model_reset();
        m_insync = 0; m_need = 0; m_even = 0; m_bad = 0;
        m_acq = 0; m_lvl = 0; m_good = 0; m_sudi = 10'h000;
    endtask

    task automatic model_step(input logic [9:0] cg);
        bit v, k, c, d, cgbad, exp_even, enter_cd;
        exp_even = !m_even;
        v        = in_list(cg, 0, 28);
        k        = in_list(cg, 20, 28);
        c        = (cg[9:3] == 7'b0011111) || (cg[9:3] == 7'b1100000);
        d        = v && !c && !k;
        cgbad    = !v || (c && !exp_even);
        enter_cd = 0;
        if (!m_insync) begin
            if (m_acq == 0) begin
                if (c) begin m_acq = 1; m_need = 1; enter_cd = 1; end
            end else if (m_need) begin
                if (d) begin
                    m_need = 0;
                    if (m_acq == 3) begin m_insync = 1; m_lvl = 0; m_good = 0; m_acq = 0; end
                end else begin
                    m_acq = 0; m_need = 0;
                end
            end else if (cgbad) begin
                m_acq = 0;
            end else if (c && exp_even) begin
                m_acq++; m_need = 1; enter_cd = 1;
            end
        end else begin
            if (cgbad) begin
                if (m_lvl == 3) begin m_insync = 0; m_acq = 0; m_need = 0; end
                else m_lvl++;
                m_good = 0;
            end else if (m_lvl > 0) begin
                m_good++;
                if (m_good == 4) begin m_lvl--; m_good = 0; end
            end
        end
        m_bad  = cgbad && (m_insync || (m_acq != 0 && !m_need));
        m_even = enter_cd ? 1'b1 : exp_even;
        m_sudi = cg;
    endtask

    task automatic chk(input string tag, input logic [9:0] obs, input logic [9:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step(input logic [9:0] cg);
        RX_CODE_GROUP = cg;
        @(posedge GTX_CLK);
        model_step(cg);
        #2;
        chk("sync_status", {9'd0, SYNC_STATUS}, {9'd0, m_insync});
        chk("rx_even",     {9'd0, RX_EVEN},     {9'd0, m_even});
        chk("sudi",        SUDI,                m_sudi);
        chk("sudi_bad",    {9'd0, SUDI_BAD},    {9'd0, m_bad});
    endtask

    task automatic acquire();
        step(K28P5N); step(D16P2); step(K28P5N); step(D16P2); step(K28P5N); step(D16P2);
    endtask

    initial begin
        int r;
        logic [9:0] cg;
        model_reset();
        #2;
        chk("reset_sync", {9'd0, SYNC_STATUS}, 10'd0);
        chk("reset_sudi", SUDI, 10'h000);
        @(negedge GTX_CLK);
        RESET = 1'b0;

        // Minimum acquisition: sync rises on the 6th code group, tags alternate from 1.
        step(K28P5N); chk("acq1_even", {9'd0, RX_EVEN}, 10'd1);
        step(D16P2);  chk("acq2_even", {9'd0, RX_EVEN}, 10'd0);
        step(K28P5N); step(D16P2); step(K28P5N);
        chk("acq5_sync", {9'd0, SYNC_STATUS}, 10'd0);
        step(D16P2);
        chk("acq6_sync", {9'd0, SYNC_STATUS}, 10'd1);

        // One invalid code group followed by four good ones: back to the top level.
        step(10'h000);
        chk("err_pulse", {9'd0, SUDI_BAD}, 10'd1);
        repeat (4) step(D0P0);
        chk("recover_sync", {9'd0, SYNC_STATUS}, 10'd1);

        // Four consecutive invalid code groups lose sync on the 4th.
        step(10'h3FF); step(10'h3FF); step(10'h3FF);
        chk("loss3_sync", {9'd0, SYNC_STATUS}, 10'd1);
        chk("loss3_bad",  {9'd0, SUDI_BAD},    10'd1);
        step(10'h3FF);
        chk("loss4_sync", {9'd0, SYNC_STATUS}, 10'd0);

        // Comma on an odd slot during acquisition restarts the search.
        step(K28P5N); step(D16P2); step(D16P2); step(K28P5N);
        chk("odd_comma_sync", {9'd0, SYNC_STATUS}, 10'd0);
        step(K28P5P);
        chk("restart_even", {9'd0, RX_EVEN}, 10'd1);
        step(D16P2); step(K28P5N); step(D16P2); step(K28P5N); step(D16P2);
        chk("reacq_sync", {9'd0, SYNC_STATUS}, 10'd1);

        // Odd-slot comma while in sync is cgbad but keeps sync.
        step(D16P2); step(K28P5N);
        chk("odd_k_bad",  {9'd0, SUDI_BAD},    10'd1);
        chk("odd_k_sync", {9'd0, SYNC_STATUS}, 10'd1);

        // Asynchronous reset mid-cycle, then held while inputs toggle.
        #2;
        RESET = 1'b1;
        #1;
        chk("arst_sync", {9'd0, SYNC_STATUS}, 10'd0);
        chk("arst_even", {9'd0, RX_EVEN},     10'd0);
        chk("arst_sudi", SUDI,                10'h000);
        chk("arst_bad",  {9'd0, SUDI_BAD},    10'd0);
        model_reset();
        for (int i = 0; i < 6; i++) begin
            RX_CODE_GROUP = (i % 2 == 0) ? K28P5N : D16P2;
            @(posedge GTX_CLK);
            #2;
            chk("hold_sync", {9'd0, SYNC_STATUS}, 10'd0);
            chk("hold_sudi", SUDI, 10'h000);
        end
        @(negedge GTX_CLK);
        RESET = 1'b0;

        // Random traffic with periodic forced acquisition attempts.
        for (int n = 0; n < 1500; n++) begin
            if (n % 150 == 0) acquire();
            r = $urandom_range(0, 99);
            if (r < 8)       cg = 10'($urandom_range(0, 1023));
            else if (r < 30) cg = ($urandom_range(0, 1) != 0) ? K28P5N : K28P5P;
            else if (r < 38) cg = CG_TBL[$urandom_range(22, 27)];
            else             cg = CG_TBL[$urandom_range(0, 19)];
            step(cg);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/pcs_rx_synchronizer.md
# pcs_rx_synchronizer

Receive-side 1000BASE-X PCS code-group synchronizer. It sits directly downstream of the transmit code-group encoder and consumes its 10-bit code-group stream. It acquires comma alignment and even/odd parity, then flags invalid code groups and loss of synchronization. It forwards aligned code groups with an even/odd tag to the receive state machine.

## Interface
Parameters:
- none; all thresholds are fixed by the state machine below.

Ports:
- `GTX_CLK` in 1: single clock; one code group per rising edge.
- `RESET` in 1: asynchronous, active-high reset.
- `RX_CODE_GROUP` in 10: incoming code group; bit [9] = bit a (first transmitted), bit [0] = bit j.
- `SYNC_STATUS` out 1: 1 = sync OK, 0 = sync FAIL.
- `RX_EVEN` out 1: even (1) / odd (0) tag of the code group on `SUDI`.
- `SUDI` out 10: code group registered from `RX_CODE_GROUP`.
- `SUDI_BAD` out 1: 1 when the code group on `SUDI` was classified cgbad.

## Operation
Classification (combinational, on `RX_CODE_GROUP`):
- valid: matches any `_rd_neg`/`_rd_pos` encoding in the shared code-group definitions file: D0.0–D0.4, D5.6, D16.0–D16.3, D21.5, K28.5, K23.7, K27.7, K29.7.
- comma: [9:3] == 7'b0011111 or 7'b1100000.
- /D/: valid, not comma, not a K code group.
- exp_even = ~RX_EVEN, i.e. the tag this code group receives unless it causes entry to a COMMA_DETECT state.
- cgbad: !valid, or (comma && !exp_even).
- cggood: !cgbad.

Tagging (registered each edge):
- Entering COMMA_DETECT_1/2/3: `RX_EVEN` <= 1.
- Otherwise: `RX_EVEN` <= exp_even.
- `SUDI` <= `RX_CODE_GROUP`.
- `SUDI_BAD` <= cgbad, forced to 0 in the LOSS_OF_SYNC and COMMA_DETECT states.

State machine (one-hot or binary; 13 states):
- LOSS_OF_SYNC:
  - comma -> COMMA_DETECT_1; else stay.
- COMMA_DETECT_n (n = 1, 2, 3):
  - /D/ -> ACQUIRE_SYNC_n; for n = 3, /D/ -> SYNC_ACQUIRED_1 instead.
  - else -> LOSS_OF_SYNC.
- ACQUIRE_SYNC_n (n = 1, 2):
  - cgbad -> LOSS_OF_SYNC.
  - comma && exp_even -> COMMA_DETECT_(n+1).
  - else stay.
- SYNC_ACQUIRED_1:
  - cgbad -> SYNC_ACQUIRED_2; else stay.
- SYNC_ACQUIRED_k (k = 2, 3, 4), entered with good_cgs <= 0:
  - cgbad -> SYNC_ACQUIRED_(k+1); for k = 4, cgbad -> LOSS_OF_SYNC.
  - cggood -> SYNC_ACQUIRED_kA, good_cgs <= 1.
- SYNC_ACQUIRED_kA:
  - cgbad -> SYNC_ACQUIRED_(k+1); for k = 4, cgbad -> LOSS_OF_SYNC. good_cgs <= 0.
  - cggood && good_cgs == 3 -> SYNC_ACQUIRED_(k-1); good_cgs <= 0. For k = 2, the destination is SYNC_ACQUIRED_1.
  - cggood && good_cgs < 3 -> stay, good_cgs <= good_cgs + 1.
- good_cgs is 2 bits wide and never wraps; the transition at 3 prevents overflow.
- `SYNC_STATUS` = 1 in every SYNC_ACQUIRED state, 0 in all others. It is registered, decoded from the state register.

## Timing
- Reset (asynchronous, immediate, any state):
  - state = LOSS_OF_SYNC.
  - `SYNC_STATUS` = 0, `RX_EVEN` = 0, `SUDI` = 10'h000, `SUDI_BAD` = 0, good_cgs = 0.
- All outputs are registered. `SUDI`, `RX_EVEN` and `SUDI_BAD` lag `RX_CODE_GROUP` by 1 cycle.
- `SYNC_STATUS` changes on the same edge that samples the deciding code group.
- Minimum acquisition is 6 code groups (comma, /D/, comma, /D/, comma, /D/). `SYNC_STATUS` rises on the edge sampling the 6th.
- Minimum loss of sync from SYNC_ACQUIRED_1 is 4 consecutive cgbad. `SYNC_STATUS` falls on the edge sampling the 4th.
- Simultaneous events:
  - comma && !valid counts as cgbad.
  - A comma in LOSS_OF_SYNC is accepted regardless of parity.
- Release of `RESET` takes effect at the first following `GTX_CLK` rising edge.

## Test plan
1. Assert `RESET` mid-stream, then hold it. All outputs must read 0 asynchronously, and `SYNC_STATUS` stays 0 while any input is applied.
2. Drive K28.5-, D16.2, K28.5, D16.2, K28.5, D16.2 after reset. `SYNC_STATUS` must go 0 -> 1 on the 6th edge, and `RX_EVEN` must read 1,0,1,0,1,0 on `SUDI`.
3. Drive K28.5, D16.2, D16.2, K28.5, where the last comma falls on an odd slot. The machine must return to LOSS_OF_SYNC, `SYNC_STATUS` stays 0, and the next K28.5 restarts COMMA_DETECT_1.
4. In sync, drive 10'h000 followed by 4 × D0.0. `SUDI_BAD` pulses once, `SYNC_STATUS` stays 1, and the machine ends in SYNC_ACQUIRED_1.
5. In sync, drive 4 × 10'h3FF back-to-back. `SYNC_STATUS` must fall on the 4th edge, and `SUDI_BAD` = 1 for the first 3 code groups.
6. In sync, drive a K28.5 at an odd slot. `SUDI_BAD` = 1, the machine moves to SYNC_ACQUIRED_2, and `SYNC_STATUS` stays 1.
